// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the ID-stage hazard/scoreboard unit.
package hazard_scoreboard_unit_pkg;

   localparam int XLEN_D = 32;
   localparam int AW_D   = 5;
   localparam int NREG_D = 32;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   localparam logic [1:0] ALUB_RS2 = 2'd0;

   // Stores and branches read rs2 even though ALU-B takes the immediate.
   function automatic logic uses_rs2(
      input logic [1:0] alub_sel,
      input logic       is_store,
      input logic       is_branch
   );
      return (alub_sel == ALUB_RS2) || is_store || is_branch;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_regs.sv
// Busy bits for long-latency destinations; x0 never busy, set beats clear.
module hazard_sb_regs
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int NREG = NREG_D,
   parameter int AW   = AW_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   output logic [NREG-1:0] busy
);

   logic [NREG-1:1] busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (set_en && set_idx == AW'(i))
               busy_q[i] <= 1'b1;
            else if (clr_en && clr_idx == AW'(i))
               busy_q[i] <= 1'b0;
         end
      end
   end

   assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage forwarding, load-use and long-op scoreboard hazards,
// with saturating stall/flush counters.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int XLEN     = XLEN_D,
   parameter int NREG     = NREG_D,
   parameter int AW       = AW_D,
   parameter int LOAD_LAT = 1,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs1,
   input  logic [AW-1:0]     id_rs2,
   input  logic [AW-1:0]     id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic              id_lo_issue,
   input  logic              ex_we,
   input  logic              mem_we,
   input  logic              wb_we,
   input  logic [AW-1:0]     ex_wr,
   input  logic [AW-1:0]     mem_wr,
   input  logic [AW-1:0]     wb_wr,
   input  logic [XLEN-1:0]   ex_wd,
   input  logic [XLEN-1:0]   mem_wd,
   input  logic [XLEN-1:0]   wb_wd,
   input  logic              ex_is_load,
   input  logic              mem_is_load,
   input  logic              lo_done,
   input  logic [AW-1:0]     lo_wr,
   input  logic              branch_taken,
   output logic [XLEN-1:0]   final_rd1,
   output logic [XLEN-1:0]   final_rd2,
   output logic              pipeline_stop,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              lo_busy_any,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   localparam logic LL2 = (LOAD_LAT >= 2);

   function automatic logic hit(
      input logic          we,
      input logic [AW-1:0] wr,
      input logic [AW-1:0] rs,
      input logic          use_rs
   );
      return we && (wr == rs) && (wr != '0) && use_rs;
   endfunction

   logic hit_ex1, hit_mem1, hit_wb1;
   logic hit_ex2, hit_mem2, hit_wb2;
   logic load_use, sb_hazard, stall, sb_set;
   logic [NREG-1:0] busy;
   fwd_sel_e sel1, sel2;

   assign hit_ex1  = hit(ex_we,  ex_wr,  id_rs1, id_use_rs1);
   assign hit_mem1 = hit(mem_we, mem_wr, id_rs1, id_use_rs1);
   assign hit_wb1  = hit(wb_we,  wb_wr,  id_rs1, id_use_rs1);
   assign hit_ex2  = hit(ex_we,  ex_wr,  id_rs2, id_use_rs2);
   assign hit_mem2 = hit(mem_we, mem_wr, id_rs2, id_use_rs2);
   assign hit_wb2  = hit(wb_we,  wb_wr,  id_rs2, id_use_rs2);

   assign load_use =
      (ex_is_load && (hit_ex1 || hit_ex2)) ||
      (LL2 && mem_is_load && (hit_mem1 || hit_mem2));

   // A hazarding load is skipped by the mux; the stall covers it.
   function automatic fwd_sel_e pick(
      input logic e,
      input logic m,
      input logic w
   );
      fwd_sel_e s;
      s = FWD_RF;
      priority case (1'b1)
         e && !ex_is_load:           s = FWD_EX;
         m && !(LL2 && mem_is_load): s = FWD_MEM;
         w:                          s = FWD_WB;
         default:                    s = FWD_RF;
      endcase
      return s;
   endfunction

   function automatic logic [XLEN-1:0] fwd_mux(
      input fwd_sel_e        s,
      input logic [XLEN-1:0] rf
   );
      logic [XLEN-1:0] v;
      v = rf;
      unique case (s)
         FWD_EX:  v = ex_wd;
         FWD_MEM: v = mem_wd;
         FWD_WB:  v = wb_wd;
         default: v = rf;
      endcase
      return v;
   endfunction

   assign sel1 = pick(hit_ex1, hit_mem1, hit_wb1);
   assign sel2 = pick(hit_ex2, hit_mem2, hit_wb2);
   assign final_rd1 = fwd_mux(sel1, id_rd1);
   assign final_rd2 = fwd_mux(sel2, id_rd2);

   assign sb_hazard = id_valid && (
      (id_use_rs1 && busy[id_rs1]) ||
      (id_use_rs2 && busy[id_rs2]) ||
      (id_lo_issue && busy[id_rd]));

   assign stall = id_valid && (load_use || sb_hazard);
   assign pipeline_stop = stall;
   assign if_id_flush = branch_taken && !stall;
   assign id_ex_flush = stall || if_id_flush;

   assign sb_set = id_valid && id_lo_issue && !stall && (id_rd != '0);
   assign lo_busy_any = |busy;

   hazard_sb_regs #(
      .NREG(NREG),
      .AW  (AW)
   ) u_sb (
      .clk    (clk),
      .rst    (rst_n),
      .set_en (sb_set),
      .set_idx(id_rd),
      .clr_en (lo_done),
      .clr_idx(lo_wr),
      .busy   (busy)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (if_id_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: vector table for forwarding/hazards, then
// sequences for load-use, scoreboard, reset and saturation.
module tb_hazard_scoreboard_unit;

   localparam logic [31:0] R1 = 32'hAAAA0001;
   localparam logic [31:0] R2 = 32'hBBBB0002;

   logic        clk, rst_n;
   logic        id_valid, id_use_rs1, id_use_rs2, id_lo_issue;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rd1, id_rd2;
   logic        ex_we, mem_we, wb_we, ex_is_load, mem_is_load;
   logic [4:0]  ex_wr, mem_wr, wb_wr, lo_wr;
   logic [31:0] ex_wd, mem_wd, wb_wd;
   logic        lo_done, branch_taken;

   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_stop, a_iff, a_idf, a_busy;
   logic        b_stop, b_iff, b_idf, b_busy;
   logic [15:0] a_scnt, a_fcnt;
   logic [3:0]  b_scnt, b_fcnt;

   int n_chk = 0;
   int n_fail = 0;

   hazard_scoreboard_unit #(.LOAD_LAT(1), .PERF_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_lo_issue(id_lo_issue),
      .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
      .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
      .ex_wd(ex_wd), .mem_wd(mem_wd), .wb_wd(wb_wd),
      .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
      .lo_done(lo_done), .lo_wr(lo_wr), .branch_taken(branch_taken),
      .final_rd1(a_rd1), .final_rd2(a_rd2),
      .pipeline_stop(a_stop), .if_id_flush(a_iff),
      .id_ex_flush(a_idf), .lo_busy_any(a_busy),
      .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
   );

   hazard_scoreboard_unit #(.LOAD_LAT(2), .PERF_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_lo_issue(id_lo_issue),
      .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
      .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
      .ex_wd(ex_wd), .mem_wd(mem_wd), .wb_wd(wb_wd),
      .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
      .lo_done(lo_done), .lo_wr(lo_wr), .branch_taken(branch_taken),
      .final_rd1(b_rd1), .final_rd2(b_rd2),
      .pipeline_stop(b_stop), .if_id_flush(b_iff),
      .id_ex_flush(b_idf), .lo_busy_any(b_busy),
      .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ex_we;
      logic [4:0]  ex_wr;
      logic [31:0] ex_wd;
      logic        ex_ld;
      logic        mem_we;
      logic [4:0]  mem_wr;
      logic [31:0] mem_wd;
      logic        mem_ld;
      logic        wb_we;
      logic [4:0]  wb_wr;
      logic [31:0] wb_wd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        use1;
      logic        use2;
      logic        br;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_stop;
      logic        e_iff;
      logic        e_idf;
      logic        e_stop2;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_lo_issue = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rd1 = R1; id_rd2 = R2;
      ex_we = 0; mem_we = 0; wb_we = 0;
      ex_wr = 0; mem_wr = 0; wb_wr = 0;
      ex_wd = 0; mem_wd = 0; wb_wd = 0;
      ex_is_load = 0; mem_is_load = 0;
      lo_done = 0; lo_wr = 0; branch_taken = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1;
      @(negedge clk);
      rst_n = 0;
   endtask

   task automatic consumer_x7();
      id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
   endtask

   initial begin
      idle();
      rst_n = 1;
      #3;
      chk("rst_stop", 32'(a_stop), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_scnt", 32'(a_scnt), 0);
      chk("rst_fcnt", 32'(a_fcnt), 0);
      chk("rst_rd1", a_rd1, R1);
      @(negedge clk);
      rst_n = 0;

      vt[0]  = '{1,5,'h11,0, 1,5,'h22,0, 0,0,0,
                 5,0,1,1, 0, 'h11,R2, 0,0,0, 0};
      vt[1]  = '{0,5,'h11,0, 1,5,'h22,0, 0,0,0,
                 5,0,1,1, 0, 'h22,R2, 0,0,0, 0};
      vt[2]  = '{0,0,0,0, 0,0,0,0, 1,5,'h33,
                 5,0,1,1, 0, 'h33,R2, 0,0,0, 0};
      vt[3]  = '{1,0,'h99,0, 0,0,0,0, 0,0,0,
                 0,0,1,1, 0, R1,R2, 0,0,0, 0};
      vt[4]  = '{1,5,'h11,0, 0,0,0,0, 0,0,0,
                 1,5,1,0, 0, R1,R2, 0,0,0, 0};
      vt[5]  = '{1,7,'hDD,1, 0,0,0,0, 0,0,0,
                 1,7,0,1, 0, R1,R2, 1,0,1, 1};
      vt[6]  = '{0,0,0,0, 1,7,'h77,1, 0,0,0,
                 1,7,0,1, 0, R1,'h77, 0,0,0, 1};
      vt[7]  = '{0,0,0,0, 0,0,0,0, 0,0,0,
                 3,4,1,1, 1, R1,R2, 0,1,1, 0};
      vt[8]  = '{1,7,'hDD,1, 0,0,0,0, 0,0,0,
                 1,7,0,1, 1, R1,R2, 1,0,1, 1};
      vt[9]  = '{1,3,'h44,0, 0,0,0,0, 1,4,'h55,
                 4,3,1,1, 0, 'h55,'h44, 0,0,0, 0};
      vt[10] = '{0,0,0,0, 1,6,'h66,0, 1,6,'h77,
                 0,6,0,1, 0, R1,'h66, 0,0,0, 0};
      vt[11] = '{0,0,0,0, 0,0,0,0, 0,5,'h33,
                 5,0,1,1, 0, R1,R2, 0,0,0, 0};

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         idle();
         id_valid = 1;
         ex_we = vt[i].ex_we; ex_wr = vt[i].ex_wr;
         ex_wd = vt[i].ex_wd; ex_is_load = vt[i].ex_ld;
         mem_we = vt[i].mem_we; mem_wr = vt[i].mem_wr;
         mem_wd = vt[i].mem_wd; mem_is_load = vt[i].mem_ld;
         wb_we = vt[i].wb_we; wb_wr = vt[i].wb_wr;
         wb_wd = vt[i].wb_wd;
         id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2;
         id_use_rs1 = vt[i].use1; id_use_rs2 = vt[i].use2;
         branch_taken = vt[i].br;
         #2;
         chk($sformatf("v%0d_rd1", i), a_rd1, vt[i].e_rd1);
         chk($sformatf("v%0d_rd2", i), a_rd2, vt[i].e_rd2);
         chk($sformatf("v%0d_stop", i), 32'(a_stop), 32'(vt[i].e_stop));
         chk($sformatf("v%0d_iff", i), 32'(a_iff), 32'(vt[i].e_iff));
         chk($sformatf("v%0d_idf", i), 32'(a_idf), 32'(vt[i].e_idf));
         chk($sformatf("v%0d_stop2", i), 32'(b_stop),
             32'(vt[i].e_stop2));
      end

      // Load-use with a branch resolving during the stall
      do_reset();
      @(negedge clk);
      idle(); consumer_x7();
      ex_we = 1; ex_wr = 7; ex_wd = 'hDD; ex_is_load = 1;
      branch_taken = 1;
      #2;
      chk("lu_a_stop", 32'(a_stop), 1);
      chk("lu_a_iff", 32'(a_iff), 0);
      chk("lu_a_idf", 32'(a_idf), 1);
      chk("lu_b_stop", 32'(b_stop), 1);
      @(negedge clk);
      idle(); consumer_x7();
      mem_we = 1; mem_wr = 7; mem_wd = 'h77; mem_is_load = 1;
      branch_taken = 1;
      #2;
      chk("lu_a_stop2", 32'(a_stop), 0);
      chk("lu_a_fwd", a_rd2, 'h77);
      chk("br_a_iff", 32'(a_iff), 1);
      chk("br_a_idf", 32'(a_idf), 1);
      chk("lu_b_stop2", 32'(b_stop), 1);
      chk("br_b_iff", 32'(b_iff), 0);
      @(negedge clk);
      idle(); consumer_x7();
      wb_we = 1; wb_wr = 7; wb_wd = 'h77;
      #2;
      chk("lu_b_stop3", 32'(b_stop), 0);
      chk("lu_b_fwd", b_rd2, 'h77);
      chk("lu_a_scnt", 32'(a_scnt), 1);
      chk("lu_b_scnt", 32'(b_scnt), 2);
      chk("br_a_fcnt", 32'(a_fcnt), 1);
      chk("br_b_fcnt", 32'(b_fcnt), 0);

      // Scoreboard RAW then WAW on x9
      do_reset();
      @(negedge clk);
      idle(); id_valid = 1; id_lo_issue = 1; id_rd = 9;
      #2;
      chk("sb_issue_stop", 32'(a_stop), 0);
      chk("sb_busy0", 32'(a_busy), 0);
      @(negedge clk);
      idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
      #2;
      chk("sb_raw_stop", 32'(a_stop), 1);
      chk("sb_busy1", 32'(a_busy), 1);
      @(negedge clk);
      idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
      lo_done = 1; lo_wr = 9;
      #2;
      chk("sb_nobypass", 32'(a_stop), 1);
      @(negedge clk);
      idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
      #2;
      chk("sb_raw_free", 32'(a_stop), 0);
      chk("sb_busy2", 32'(a_busy), 0);
      chk("sb_scnt1", 32'(a_scnt), 2);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle(); id_valid = 1; id_lo_issue = 1; id_rd = 9;
         lo_done = (c >= 2); lo_wr = 9;
         #2;
         chk($sformatf("sb_waw%0d", c), 32'(a_stop),
             32'((c == 1 || c == 2) ? 1 : 0));
      end
      @(negedge clk);
      idle();
      #2;
      chk("sb_setwins", 32'(a_busy), 1);
      chk("sb_scnt2", 32'(a_scnt), 4);

      // Asynchronous reset while a long op is outstanding
      #1 rst_n = 1;
      #1;
      chk("ar_busy", 32'(a_busy), 0);
      chk("ar_busy_b", 32'(b_busy), 0);
      chk("ar_scnt", 32'(a_scnt), 0);
      @(negedge clk);
      rst_n = 0;
      idle(); id_valid = 1; id_rs1 = 9; id_use_rs1 = 1;
      lo_done = 1; lo_wr = 9;
      #2;
      chk("ar_late_done", 32'(a_stop), 0);
      @(negedge clk);
      idle();
      #2;
      chk("ar_busy2", 32'(a_busy), 0);

      // Saturation of the 4-bit counter
      do_reset();
      repeat (20) begin
         @(negedge clk);
         idle(); consumer_x7();
         ex_we = 1; ex_wr = 7; ex_is_load = 1;
      end
      @(negedge clk);
      idle();
      #2;
      chk("sat_b_scnt", 32'(b_scnt), 15);
      chk("sat_a_scnt", 32'(a_scnt), 20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation ID-stage hazard unit for the 5-stage pipeline.
- Forwards EX/MEM/WB results to both ID source operands and detects load-use hazards for a configurable load latency.
- Adds a register scoreboard for out-of-pipe multi-cycle ops (mul/div) with RAW/WAW stalls, and saturating stall/flush performance counters.

Parameters:
XLEN, 32, datapath width.
NREG, 32, architectural register count; register 0 is hardwired zero.
AW, 5, register index width, equal to clog2(NREG).
LOAD_LAT, 1, load-use distance in stages: 1 means only an EX load hazards; 2 means an EX or MEM load hazards.
PERF_W, 16, performance counter width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-high (asserted = 1)
id_valid  in  1  ID holds a valid instruction
id_rs1  in  AW  rs1 index
id_rs2  in  AW  rs2 index
id_rd  in  AW  ID destination index
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2 (not an I/U/J immediate)
id_rd1  in  XLEN  regfile read data 1
id_rd2  in  XLEN  regfile read data 2
id_lo_issue  in  1  ID instruction is a long-latency op writing id_rd
ex_we, mem_we, wb_we  in  1 each  stage register write enables
ex_wr, mem_wr, wb_wr  in  AW each  stage destination indices
ex_wd, mem_wd, wb_wd  in  XLEN each  stage result data
ex_is_load, mem_is_load  in  1 each  stage holds a load
lo_done  in  1  long op completes; regfile written at this edge
lo_wr  in  AW  completing destination
branch_taken  in  1  branch resolved taken in ID
final_rd1  out  XLEN  forwarded operand 1
final_rd2  out  XLEN  forwarded operand 2
pipeline_stop  out  1  hold PC and IF/ID
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  insert bubble into ID/EX
lo_busy_any  out  1  any scoreboard bit set
stall_cnt  out  PERF_W  cycles with pipeline_stop=1
flush_cnt  out  PERF_W  cycles with if_id_flush=1

Behaviour:
- Match on stage X for operand n: X_we && X_wr==rsn && X_wr!=0 && id_use_rsn.
- Forwarding is combinational. Priority EX > MEM > WB > regfile. Unused or x0 operand passes id_rdN unchanged.
- Load-use hazard:
  - Any EX match with ex_is_load.
  - If LOAD_LAT>=2, also any MEM match with mem_is_load.
  - A hazarding load is never forwarded; a stall is raised instead.
- Scoreboard busy[NREG] is registered; bit 0 is constant 0.
- sb_hazard: id_valid and any of:
  - used rs1 busy
  - used rs2 busy
  - id_lo_issue with busy[id_rd] (WAW)
- stall = id_valid && (load_use || sb_hazard).
- Outputs:
  - pipeline_stop = stall.
  - id_ex_flush = stall || (branch_taken && !stall).
  - if_id_flush = branch_taken && !stall. A stalled branch's operands are stale, so branch_taken is ignored while stalled.
- Scoreboard update on each clk edge:
  - Set busy[id_rd] when id_valid && id_lo_issue && !stall && id_rd!=0.
  - Clear busy[lo_wr] when lo_done.
  - Same index set and clear in one cycle: set wins. This is legal only for back-to-back reuse after completion.
  - No same-cycle bypass of lo_done: the dependent leaves the stall the cycle after lo_done.
- Counters:
  - stall_cnt +1 per stall cycle; flush_cnt +1 per if_id_flush cycle.
  - Both saturate at all-ones and never wrap.
- lo_busy_any = OR of busy.
- Reset (rst_n=1, asynchronous): busy=0, stall_cnt=0, flush_cnt=0.
  - With busy cleared, combinational outputs follow inputs.
  - Reset mid-long-op drops its busy bit; a later lo_done for that index is harmless (clears an already-clear bit).

Decomposition:
- Shared package holds:
  - AW/XLEN defaults
  - forwarding-source encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB
  - the ALUB_RS2 constant, used by the controller to derive id_use_rs2
- One natural sub-module, hazard_sb_regs: scoreboard array with set/clear and a busy-read port.

Test Plan:
- Forwarding: ex add writes x5=0x11, mem writes x5=0x22, rs1=x5 -> final_rd1=0x11, no stall. Remove ex -> 0x22. Remove mem, wb x5=0x33 -> 0x33.
- x0 and immediates: ex_wr=0 with ex_we=1 and rs1=0 -> final_rd1=id_rd1. id_use_rs2=0 with rs2 match -> final_rd2=id_rd2.
- Load-use: LOAD_LAT=1, ex load x7, rs2=x7 used -> pipeline_stop=1 and id_ex_flush=1 for exactly 1 cycle, then MEM forward. LOAD_LAT=2 -> 2 stall cycles.
- Scoreboard: issue div x9, then a consumer of x9 -> stall until the cycle after lo_done(lo_wr=9). A WAW issue to x9 stalls likewise. stall_cnt equals the stall cycles.
- Branch vs stall: branch_taken=1 during a load-use stall -> if_id_flush=0. Next cycle without stall -> if_id_flush=1, id_ex_flush=1, flush_cnt+1.
- Reset and saturation: PERF_W=4, stall 20 cycles -> stall_cnt=15. Assert rst_n mid-long-op -> busy cleared, lo_busy_any=0 immediately.
